// File: rtl/ahb_burst_master_if.sv
// Command, write/read data and AHB-Lite signal bundle for ahb_burst_master.
// The master modport is the burst engine's view; the slave modport is the bus/command side.
interface ahb_burst_master_if;
    // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // the requester holds every cmd_* field stable while cmd_valid is high and not yet accepted.
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [2:0]  cmd_burst;
    logic [3:0]  cmd_len;

    logic [31:0] wdata;
    logic        wdata_pop;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        done_err;

    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len, wdata,
        input  HREADY, HRESP, HRDATA,
        output cmd_ready, wdata_pop, rdata, rdata_valid, done, done_err,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len, wdata,
        output HREADY, HRESP, HRDATA,
        input  cmd_ready, wdata_pop, rdata, rdata_valid, done, done_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a SINGLE/INCR/WRAP burst, with
// up-front rejection of illegal commands and two-cycle ERROR response handling.
module ahb_burst_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    ahb_burst_master_if.master         bus,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LAST = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;
    localparam logic [2:0] BURST_WRAP4  = 3'd2;
    localparam logic [2:0] BURST_INCR4  = 3'd3;
    localparam logic [2:0] BURST_WRAP8  = 3'd4;
    localparam logic [2:0] BURST_INCR8  = 3'd5;
    localparam logic [2:0] BURST_WRAP16 = 3'd6;
    localparam logic [2:0] BURST_INCR16 = 3'd7;

    state_t      state_q, state_d;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [2:0]  hburst_q;
    logic        first_q;
    logic [4:0]  beats_left_q;
    logic [7:0]  wrap_mask_q;
    logic        wrap_q;
    logic        reject_q;
    logic        dph_valid_q;
    logic        dph_write_q;

    logic [4:0]  cmd_beats;
    logic [7:0]  cmd_span;
    logic        cmd_misaligned;
    logic        cmd_fixed_incr;
    logic        cmd_cross_1k;
    logic        cmd_wrap;
    logic        bad_cmd;
    logic        accept;
    logic [31:0] incr_amt;
    logic [31:0] addr_inc;
    logic [31:0] addr_next;
    logic [31:0] wrap_mask32;
    logic        err_first;
    logic        addr_accept;
    logic [1:0]  htrans;

    // ---------------- command decode ----------------
    always_comb begin
        cmd_beats = 5'd1;
        case (bus.cmd_burst)
            BURST_SINGLE:              cmd_beats = 5'd1;
            BURST_INCR:                cmd_beats = {1'b0, bus.cmd_len} + 5'd1;
            BURST_WRAP4, BURST_INCR4:  cmd_beats = 5'd4;
            BURST_WRAP8, BURST_INCR8:  cmd_beats = 5'd8;
            BURST_WRAP16, BURST_INCR16: cmd_beats = 5'd16;
            default:                   cmd_beats = 5'd1;
        endcase
    end

    // Total bytes covered by the burst; doubles as the wrap window size.
    assign cmd_span = {3'b000, cmd_beats} << bus.cmd_size[1:0];

    always_comb begin
        cmd_misaligned = 1'b0;
        case (bus.cmd_size)
            3'd1:    cmd_misaligned = bus.cmd_addr[0];
            3'd2:    cmd_misaligned = |bus.cmd_addr[1:0];
            default: cmd_misaligned = 1'b0;
        endcase
    end

    assign cmd_fixed_incr = (bus.cmd_burst == BURST_INCR4) ||
                            (bus.cmd_burst == BURST_INCR8) ||
                            (bus.cmd_burst == BURST_INCR16);
    assign cmd_wrap       = (bus.cmd_burst == BURST_WRAP4) ||
                            (bus.cmd_burst == BURST_WRAP8) ||
                            (bus.cmd_burst == BURST_WRAP16);
    assign cmd_cross_1k   = ({1'b0, bus.cmd_addr[9:0]} + {3'b000, cmd_span}) > 11'h400;
    assign bad_cmd        = (bus.cmd_size > 3'd2) || cmd_misaligned ||
                            (cmd_fixed_incr && cmd_cross_1k);

    // A reject pulses done in the following IDLE cycle, so ready stays low then.
    assign bus.cmd_ready = (state_q == S_IDLE) && !reject_q;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // ---------------- address sequencing ----------------
    assign incr_amt    = 32'd1 << hsize_q[1:0];
    assign addr_inc    = haddr_q + incr_amt;
    assign wrap_mask32 = {24'h000000, wrap_mask_q};
    assign addr_next   = wrap_q ? ((haddr_q & ~wrap_mask32) | (addr_inc & wrap_mask32))
                                : addr_inc;

    // First cycle of a two-cycle ERROR response on the outstanding data phase.
    assign err_first = dph_valid_q && bus.HRESP && !bus.HREADY;

    // ---------------- FSM ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        htrans  = HTRANS_IDLE;
        case (state_q)
            S_IDLE: begin
                if (accept && !bad_cmd) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (err_first) begin
                    state_d = S_ERR;
                end else begin
                    htrans = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if (bus.HREADY && (beats_left_q == 5'd1)) state_d = S_LAST;
                end
            end
            S_LAST: begin
                if (err_first)       state_d = S_ERR;
                else if (bus.HREADY) state_d = S_IDLE;
            end
            S_ERR: begin
                if (bus.HREADY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign addr_accept = (htrans != HTRANS_IDLE) && bus.HREADY;

    // ---------------- datapath registers ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q      <= 32'h0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'd0;
            hburst_q     <= 3'd0;
            first_q      <= 1'b0;
            beats_left_q <= 5'd0;
            wrap_mask_q  <= 8'd0;
            wrap_q       <= 1'b0;
            reject_q     <= 1'b0;
            dph_valid_q  <= 1'b0;
            dph_write_q  <= 1'b0;
        end else begin
            reject_q <= accept && bad_cmd;
            if (accept && !bad_cmd) begin
                haddr_q      <= bus.cmd_addr;
                hwrite_q     <= bus.cmd_write;
                hsize_q      <= bus.cmd_size;
                hburst_q     <= bus.cmd_burst;
                first_q      <= 1'b1;
                beats_left_q <= cmd_beats;
                wrap_mask_q  <= cmd_span - 8'd1;
                wrap_q       <= cmd_wrap;
            end else if (addr_accept) begin
                beats_left_q <= beats_left_q - 5'd1;
                if (beats_left_q != 5'd1) begin
                    haddr_q <= addr_next;
                    // Undefined-length INCR restarts as NONSEQ on each 1 KB boundary.
                    first_q <= (hburst_q == BURST_INCR) && (addr_next[9:0] == 10'h000);
                end
            end
            if (bus.HREADY) begin
                dph_valid_q <= addr_accept;
                if (addr_accept) dph_write_q <= hwrite_q;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.HADDR     = haddr_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = hburst_q;
    assign bus.HTRANS    = htrans;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = (dph_valid_q && dph_write_q) ? bus.wdata : 32'h0;

    assign bus.wdata_pop   = dph_valid_q && dph_write_q && bus.HREADY && !bus.HRESP;
    assign bus.rdata_valid = dph_valid_q && !dph_write_q && bus.HREADY && !bus.HRESP;
    assign bus.rdata       = bus.rdata_valid ? bus.HRDATA : 32'h0;

    assign bus.done     = reject_q || (((state_q == S_LAST) || (state_q == S_ERR)) && bus.HREADY);
    assign bus.done_err = reject_q || ((state_q == S_ERR) && bus.HREADY);

    assign state_dbg = state_q;

endmodule

// File: doc/ahb_burst_master.md
AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, constant value driven on HPROT (non-cacheable, non-bufferable, privileged data).
REQ-002 SHALL have port HCLK  in  1  bus clock; all state changes on the rising edge.
REQ-003 SHALL have port HRESETn  in  1  reset: asynchronous assert, active-low.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_addr  in  32  start address.
REQ-007 SHALL have port cmd_write  in  1  1 write, 0 read.
REQ-008 SHALL have port cmd_size  in  3  hsize_type encoding.
REQ-009 SHALL have port cmd_burst  in  3  hburst_type encoding.
REQ-010 SHALL have port cmd_len  in  4  beats-1, used only for INCR.
REQ-011 SHALL have port wdata  in  32  write data for the current data-phase beat, held until wdata_pop.
REQ-012 SHALL have port wdata_pop  out  1  write beat data phase completed.
REQ-013 SHALL have port rdata / rdata_valid  out  32 / 1  read beat data, one-cycle valid pulse.
REQ-014 SHALL have port done / done_err  out  1 / 1  command finished pulse; done_err qualifies it.
REQ-015 SHALL have ports HADDR[31:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0], HMASTLOCK, HWDATA[31:0]  out  AHB-Lite master outputs.
REQ-016 SHALL have ports HREADY, HRESP, HRDATA[31:0]  in  AHB-Lite slave response.

Function
REQ-017 SHALL implement states IDLE, ADDR, LAST, ERR; cmd_ready=1 only in IDLE.
REQ-018 On acceptance, SHALL compute beats: SINGLE 1, INCR cmd_len+1, WRAP4/INCR4 4, WRAP8/INCR8 8, WRAP16/INCR16 16; go to ADDR.
REQ-019 SHALL reject (no bus activity, done=done_err=1 next cycle, stay IDLE) when cmd_size>WORD, cmd_addr misaligned to size, or a fixed INCRn burst crosses a 1 KB boundary.
REQ-020 ADDR: first beat HTRANS=NONSEQ, subsequent beats SEQ; HADDR/HWRITE/HSIZE/HBURST from the command; address and control advance only on cycles with HREADY=1.
REQ-021 Increment = 1<<size; INCR-type next = addr+incr; WRAP-type next = (addr & ~M) | ((addr+incr) & M), M = beats*incr-1.
REQ-022 INCR (undefined length) crossing a 1 KB boundary SHALL continue as NONSEQ at the boundary address, SEQ thereafter; beat count unaffected.
REQ-023 When the last address phase is accepted, SHALL go to LAST with HTRANS=IDLE; on HREADY=1 in LAST, pulse done (done_err=0) and return to IDLE.
REQ-024 HWDATA SHALL equal wdata during every write data phase; wdata_pop=1 on the cycle a write data phase completes (HREADY=1, HRESP=0).
REQ-025 rdata=HRDATA, rdata_valid=1 on the cycle a read data phase completes (HREADY=1, HRESP=0).
REQ-026 On HRESP=1 with HREADY=0 (first error cycle), SHALL drive HTRANS=IDLE that same cycle combinationally, cancel remaining beats, enter ERR; on HREADY=1 in ERR pulse done with done_err=1, return to IDLE; no wdata_pop/rdata_valid for the errored beat.
REQ-027 HTRANS SHALL never be BUSY; HMASTLOCK=0 constant; HPROT=HPROT_VAL.
REQ-028 A new command SHALL be accepted no earlier than the cycle after done.

Reset
REQ-029 On HRESETn=0, asynchronously: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, cmd_ready=1 after release, wdata_pop=rdata_valid=done=done_err=0, rdata=0; in-flight command discarded.

Verification
REQ-030 Write SINGLE word 0x100, HREADY=1 -> NONSEQ 0x100 one cycle, IDLE next, wdata_pop and done same cycle.
REQ-031 Read WRAP4 word 0x38 -> HADDR 0x38,0x3C,0x30,0x34 (NONSEQ,SEQ,SEQ,SEQ), four rdata_valid pulses, done.
REQ-032 Write INCR8 halfword 0x20, HREADY=0 two cycles on beat 3 -> HADDR/HTRANS held, beat 4 issued after stall, 8 wdata_pop pulses.
REQ-033 Read INCR len 3 word 0x3F8 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
REQ-034 Write INCR4 word 0x3F8 -> rejected, no NONSEQ, done=done_err=1; INCR4 at 0x10, error on beat 2 -> HTRANS=IDLE in first error cycle, done_err=1, one wdata_pop total.
REQ-035 HRESETn low during beat 2 of INCR16 -> all outputs at reset values immediately; after release cmd_ready=1, no residual transfers.
